// File: rtl/adder.sv
// Multi-cycle binary32 adder: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND, round-to-nearest-even.
// Define ADDER_SUBNORMAL_EN for gradual underflow; the default build flushes subnormals to zero.
module adder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        En,
    output logic [31:0] Sum,
    output logic        Ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_accept;
    logic   w_done;

    // Pipeline-of-one datapath registers, one group per FSM stage
    logic [31:0] r_a, r_b;
    logic        r_special;
    logic [31:0] r_special_val;
    logic        r_sx, r_sub;
    logic [9:0]  r_ex, r_ey;
    logic [23:0] r_mx, r_my;
    logic [26:0] r_my_al;
    logic [27:0] r_add;
    logic [26:0] r_man;
    logic [9:0]  r_en;
    logic        r_zero, r_zero_sign;
    logic [31:0] r_sum;
    logic        r_ready;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (En) w_next = S_UNPACK;
            S_UNPACK: w_next = S_ALIGN;
            S_ALIGN:  w_next = S_ADD;
            S_ADD:    w_next = S_NORM;
            S_NORM:   w_next = S_ROUND;
            S_ROUND:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = (r_state == S_IDLE) && En && !reset;
        w_done   = (r_state == S_ROUND);
    end

    // ---------------- UNPACK ----------------
    logic [7:0]  w_ea, w_eb;
    logic [22:0] w_fa, w_fb;
    logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic [9:0]  w_exp_a, w_exp_b;
    logic [23:0] w_sig_a, w_sig_b;
    logic        w_spec;
    logic [31:0] w_spec_val;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_ea    = r_a[30:23];
        w_eb    = r_b[30:23];
        w_fa    = r_a[22:0];
        w_fb    = r_b[22:0];
        w_nan_a = (w_ea == 8'hFF) && (w_fa != '0);
        w_nan_b = (w_eb == 8'hFF) && (w_fb != '0);
        w_inf_a = (w_ea == 8'hFF) && (w_fa == '0);
        w_inf_b = (w_eb == 8'hFF) && (w_fb == '0);
        w_sig_a = {(w_ea != 8'h00), w_fa};
        w_sig_b = {(w_eb != 8'h00), w_fb};
`ifdef ADDER_SUBNORMAL_EN
        w_zero_a = (r_a[30:0] == '0);
        w_zero_b = (r_b[30:0] == '0);
        w_exp_a  = (w_ea == 8'h00) ? 10'd1 : {2'b00, w_ea};
        w_exp_b  = (w_eb == 8'h00) ? 10'd1 : {2'b00, w_eb};
`else
        w_zero_a = (w_ea == 8'h00);
        w_zero_b = (w_eb == 8'h00);
        w_exp_a  = {2'b00, w_ea};
        w_exp_b  = {2'b00, w_eb};
`endif
        w_spec     = 1'b1;
        w_spec_val = 32'h0000_0000;
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (r_a[31] != r_b[31])))
            w_spec_val = 32'h7FC0_0000;
        else if (w_inf_a)               w_spec_val = r_a;
        else if (w_inf_b)               w_spec_val = r_b;
        else if (w_zero_a && w_zero_b)  w_spec_val = {r_a[31] & r_b[31], 31'h0};
        else if (w_zero_a)              w_spec_val = r_b;
        else if (w_zero_b)              w_spec_val = r_a;
        else                            w_spec     = 1'b0;
    end

    // ---------------- ALIGN ----------------
    logic [9:0]  w_shift;
    logic [49:0] w_wide;
    logic [26:0] w_y_al;

    always_comb begin
        w_shift = r_ex - r_ey;
        w_wide  = {r_my, 26'h0} >> w_shift[4:0];
        if (w_shift >= 10'd26) w_y_al = {26'h0, |r_my};
        else                   w_y_al = {w_wide[49:24], |w_wide[23:0]};
    end

    // ---------------- ADD ----------------
    logic [27:0] w_add;

    always_comb begin
        if (r_sub) w_add = {1'b0, r_mx, 3'b000} - {1'b0, r_my_al};
        else       w_add = {1'b0, r_mx, 3'b000} + {1'b0, r_my_al};
    end

    // ---------------- NORM ----------------
    logic [4:0]  w_lzc;
    logic [26:0] w_man;
    logic [9:0]  w_en;
    logic        w_zero, w_zero_sign;
`ifdef ADDER_SUBNORMAL_EN
    logic [4:0]  w_shamt;
`endif

    always_comb begin
        w_lzc       = lzc27(r_add[26:0]);
        w_man       = r_add[26:0];
        w_en        = r_ex;
        w_zero      = 1'b0;
        w_zero_sign = 1'b0;
`ifdef ADDER_SUBNORMAL_EN
        w_shamt     = 5'd0;
`endif
        if (r_add == '0) begin
            w_zero = 1'b1;
        end else if (r_add[27]) begin
            w_man = {r_add[27:2], r_add[1] | r_add[0]};
            w_en  = r_ex + 10'd1;
        end else begin
`ifdef ADDER_SUBNORMAL_EN
            // Left shift stops at exponent 1; a leftover leading zero means a subnormal result
            if ({5'b0, w_lzc} < r_ex) w_shamt = w_lzc;
            else                      w_shamt = 5'(r_ex - 10'd1);
            w_man = r_add[26:0] << w_shamt;
            w_en  = r_ex - {5'b0, w_shamt};
`else
            if ({5'b0, w_lzc} >= r_ex) begin
                w_zero      = 1'b1;
                w_zero_sign = r_sx;
            end else begin
                w_man = r_add[26:0] << w_lzc;
                w_en  = r_ex - {5'b0, w_lzc};
            end
`endif
        end
    end

    // ---------------- ROUND ----------------
    logic        w_up;
    logic [24:0] w_rsig;
    logic [23:0] w_fsig;
    logic [9:0]  w_fexp;
    logic [31:0] w_result;

    always_comb begin
        w_up   = r_man[2] & (r_man[1] | r_man[0] | r_man[3]);
        w_rsig = {1'b0, r_man[26:3]} + {24'h0, w_up};
        if (w_rsig[24]) begin
            w_fsig = w_rsig[24:1];
            w_fexp = r_en + 10'd1;
        end else begin
            w_fsig = w_rsig[23:0];
            w_fexp = r_en;
        end
        if (r_special)             w_result = r_special_val;
        else if (r_zero)           w_result = {r_zero_sign, 31'h0};
        else if (w_fexp >= 10'd255) w_result = {r_sx, 8'hFF, 23'h0};
        else                       w_result = {r_sx, (w_fsig[23] ? w_fexp[7:0] : 8'h00), w_fsig[22:0]};
    end

    // ---------------- Datapath registers ----------------
    // NOTE: datapath registers carry no reset; every one is written before it is read in an operation.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= A;
            r_b <= B;
        end
        case (r_state)
            S_UNPACK: begin
                r_special     <= w_spec;
                r_special_val <= w_spec_val;
                r_sub         <= r_a[31] ^ r_b[31];
                if (r_a[30:0] >= r_b[30:0]) begin
                    r_sx <= r_a[31]; r_ex <= w_exp_a; r_mx <= w_sig_a;
                    r_ey <= w_exp_b; r_my <= w_sig_b;
                end else begin
                    r_sx <= r_b[31]; r_ex <= w_exp_b; r_mx <= w_sig_b;
                    r_ey <= w_exp_a; r_my <= w_sig_a;
                end
            end
            S_ALIGN: r_my_al <= w_y_al;
            S_ADD:   r_add   <= w_add;
            S_NORM: begin
                r_man       <= w_man;
                r_en        <= w_en;
                r_zero      <= w_zero;
                r_zero_sign <= w_zero_sign;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum   <= 32'h0;
            r_ready <= 1'b0;
        end else if (w_accept) begin
            r_ready <= 1'b0;
        end else if (w_done) begin
            r_sum   <= w_result;
            r_ready <= 1'b1;
        end
    end

    assign Sum   = r_sum;
    assign Ready = r_ready;

endmodule

// File: tb/tb_adder.sv
// Bench for adder: directed vectors, handshake/reset scenarios and random operands against
// an exact-integer reference model; honours ADDER_SUBNORMAL_EN like the design.
module tb_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic        En;
    logic [31:0] Sum;
    logic        Ready;

    adder dut (
        .clk  (clk),
        .reset(reset),
        .A    (A),
        .B    (B),
        .En   (En),
        .Sum  (Sum),
        .Ready(Ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } op_t;

    op_t         sb_q[$];
    op_t         mon_item;
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_result;
    logic        ready_prev = 1'b0;

    localparam int N_DIR = 11;
    localparam logic [31:0] DIR_A [N_DIR] = '{
        32'h3F800000, 32'h42C80000, 32'h40B80000, 32'hBFC00000, 32'hC1200000, 32'h7F000000,
        32'h7E800000, 32'hC0000000, 32'hBF800000, 32'h02000000, 32'h00000000};
    localparam logic [31:0] DIR_B [N_DIR] = '{
        32'h40000000, 32'h41E00000, 32'hC0B80000, 32'h40200000, 32'hC0C00000, 32'h7F000000,
        32'h7F000000, 32'h1F000000, 32'h1F000000, 32'h01000000, 32'h41C80000};
    localparam logic [31:0] DIR_E [N_DIR] = '{
        32'h40400000, 32'h43000000, 32'h00000000, 32'h3F800000, 32'hC1800000, 32'h7F800000,
        32'h7F400000, 32'hC0000000, 32'hBF800000, 32'h02200000, 32'h41C80000};
    localparam logic [31:0] SPECIALS [6] = '{
        32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    // Exact value as an integer count of 2^-149 units, then round-to-nearest-even into binary32.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic         na, nb, ia, ib, za, zb, s;
        logic [287:0] va, vb, v, q, rem, half, one;
        logic [63:0]  bits;
        int           p, k;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
`ifdef ADDER_SUBNORMAL_EN
        za = (a[30:0] == 0);
        zb = (b[30:0] == 0);
`else
        za = (a[30:23] == 0);
        zb = (b[30:23] == 0);
`endif
        if (na || nb) return 32'h7FC00000;
        if (ia && ib) return (a[31] == b[31]) ? a : 32'h7FC00000;
        if (ia) return a;
        if (ib) return b;
        if (za && zb) return {a[31] & b[31], 31'h0};
        if (za) return b;
        if (zb) return a;
        va = 288'(a[22:0]);
        if (a[30:23] != 0) va = 288'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1);
        vb = 288'(b[22:0]);
        if (b[30:23] != 0) vb = 288'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1);
        if (a[31] == b[31]) begin v = va + vb; s = a[31]; end
        else if (va >= vb)  begin v = va - vb; s = a[31]; end
        else                begin v = vb - va; s = b[31]; end
        if (v == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 288; i++) if (v[i]) p = i;
        if (p <= 23) begin
`ifndef ADDER_SUBNORMAL_EN
            if (p <= 22) return {s, 31'h0};
`endif
            return {s, v[30:0]};
        end
        k    = p - 23;
        one  = 288'd1;
        q    = v >> k;
        rem  = v & ((one << k) - one);
        half = one << (k - 1);
        if (rem > half || (rem == half && q[0])) q = q + one;
        bits = (64'(k) << 23) + q[63:0];
        if (bits >= 64'h7F80_0000) return {s, 8'hFF, 23'h0};
        return {s, bits[30:0]};
    endfunction

    task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
        int         mode;
        logic [7:0] e;
        mode = int'($urandom_range(0, 6));
        a = $urandom;
        b = $urandom;
        case (mode)
            1: begin
                e = 8'($urandom_range(1, 253));
                a[30:23] = e;
                b[30:23] = e + 8'($urandom_range(0, 1));
            end
            2: begin
                a[30:23] = 8'($urandom_range(0, 3));
                b[30:23] = 8'($urandom_range(0, 3));
            end
            3: begin
                a[30:23] = 8'($urandom_range(250, 254));
                b[30:23] = 8'($urandom_range(250, 254));
            end
            4: a = SPECIALS[$urandom_range(0, 5)];
            5: begin
                a[30:23] = 8'($urandom_range(1, 254));
                b = a ^ 32'h8000_0000;
                b[3:0] = 4'($urandom);
            end
            6: begin
                e = 8'($urandom_range(31, 254));
                a[30:23] = e;
                b[30:23] = e - 8'($urandom_range(20, 30));
            end
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) begin
            e = a[7:0];
            {a, b} = {b, a};
        end
    endtask

    // Monitor: every rising Ready must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (Ready === 1'b1 && ready_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %08h expected no result", Sum);
            end else begin
                mon_item = sb_q.pop_front();
                check($sformatf("sum %08h+%08h", mon_item.a, mon_item.b), Sum, mon_item.e);
            end
        end
        ready_prev = Ready;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        @(negedge clk);
        A  = a;
        B  = b;
        En = 1'b1;
        @(posedge clk);
        sb_q.push_back('{a: a, b: b, e: e});
    endtask

    task automatic wait_result(input int edges, input logic [31:0] e);
        int n;
        n = 0;
        while (Ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(edges));
        last_result = e;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        issue(a, b, e);
        @(negedge clk);
        En = 1'b0;
        check("ready_low_at_accept", {31'h0, Ready}, 32'h0);
        check("sum_hold_at_accept", Sum, last_result);
        wait_result(5, e);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("ready_level", {31'h0, Ready}, 32'h1);
            check("sum_stable", Sum, e);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        En = 1'b0;
        A = '0;
        B = '0;
        reset = 1'b1;
        last_result = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'h0, Ready}, 32'h0);
        check("reset_sum", Sum, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < N_DIR; i++) run_op(DIR_A[i], DIR_B[i], DIR_E[i]);

        // En held for two edges: one accept only
        issue(32'h3F800000, 32'h40000000, 32'h40400000);
        @(posedge clk);
        @(negedge clk);
        En = 1'b0;
        check("hold2_ready_low", {31'h0, Ready}, 32'h0);
        wait_result(4, 32'h40400000);
        repeat (4) begin
            @(negedge clk);
            check("hold2_ready_level", {31'h0, Ready}, 32'h1);
        end

        // En held through completion: a second accept on the return to IDLE
        issue(32'hC1200000, 32'hC0C00000, 32'hC1800000);
        repeat (6) @(posedge clk);
        sb_q.push_back('{a: 32'hC1200000, b: 32'hC0C00000, e: 32'hC1800000});
        @(negedge clk);
        En = 1'b0;
        check("reaccept_ready_low", {31'h0, Ready}, 32'h0);
        check("reaccept_sum_hold", Sum, 32'hC1800000);
        wait_result(5, 32'hC1800000);

        // Reset and En together: reset wins
        @(negedge clk);
        reset = 1'b1;
        En = 1'b1;
        A = 32'h3F800000;
        B = 32'h3F800000;
        @(negedge clk);
        reset = 1'b0;
        En = 1'b0;
        check("reset_en_ready", {31'h0, Ready}, 32'h0);
        check("reset_en_sum", Sum, 32'h0);
        repeat (7) begin
            @(negedge clk);
            check("reset_en_idle", {31'h0, Ready}, 32'h0);
        end

        // Reset mid-operation aborts with no result
        @(negedge clk);
        A = 32'h40B80000;
        B = 32'h3F800000;
        En = 1'b1;
        @(negedge clk);
        En = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", {31'h0, Ready}, 32'h0);
        check("abort_sum", Sum, 32'h0);
        repeat (8) begin
            @(negedge clk);
            check("abort_no_result", {31'h0, Ready}, 32'h0);
        end
        last_result = 32'h0;

        for (int i = 0; i < 300; i++) begin
            gen_pair(ra, rb);
            run_op(ra, rb, model(ra, rb));
        end

        repeat (2) @(negedge clk);
        check("pending_results", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
